ram_dma: RTL

//  Bus initiator for the single-port-pair data RAM: drives its write port
//  (wr_en/wr_addr/wr_data) and read port (rd_addr -> rd_data, 1-clk sync read,

---
 rtl/ram_dma_if.sv | 28 ++
 rtl/ram_dma.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ram_dma_if.sv
// RAM port bundle between the DMA initiator and the data RAM.
// master drives write port and read address; slave returns read data.
interface ram_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/ram_dma.sv
// Word block copy (overlap-safe) / constant fill engine on the data RAM.
// Ports: clk, rst, start/mode/src/dst/len/fill/abort in; busy/done/aborted out; ram bus.
module ram_dma #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  ram_dma_if.master         ram
);

  localparam int EXT_W = ADDR_W + LEN_W + 3;

  typedef enum logic [2:0] {
    IDLE, CPY, DRAIN, FILL, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W-1:0] rd_hold, wr_addr_hold;
  logic [DATA_W-1:0] fill_q, wr_data_hold;
  logic [LEN_W-1:0]  cnt;
  logic              back, fill_mode;
  logic              rd_pend, aborted_q;
  logic              rd_en, wr_en, active;

  logic [ADDR_W-1:0] src_a, dst_a, ofs, step;
  logic [EXT_W-1:0]  src_end;
  logic              back_nx;

  // Overlap check is done in a widened space so a block that runs
  // past the top of memory still compares correctly.
  always_comb begin
    src_a   = {src_addr_i[ADDR_W-1:2], 2'b00};
    dst_a   = {dst_addr_i[ADDR_W-1:2], 2'b00};
    ofs     = ADDR_W'({len_i - LEN_W'(1), 2'b00});
    src_end = EXT_W'(src_a) + (EXT_W'(len_i) << 2);
    back_nx = !mode_i && (dst_a > src_a) &&
              (EXT_W'(dst_a) < src_end);
    step    = back ? {{(ADDR_W-2){1'b1}}, 2'b00}
                   : ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) state_nx = DONE;
          else if (mode_i) state_nx = FILL;
          else             state_nx = CPY;
        end
      end
      CPY: begin
        if (abort_i)                state_nx = DONE;
        else if (cnt == LEN_W'(1))  state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      FILL: begin
        if (abort_i)                state_nx = DONE;
        else if (cnt == LEN_W'(1))  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address/data outputs show the live pointer only while a transfer
  // beat is active, otherwise the last driven value.
  always_comb begin
    active    = (state == CPY) || (state == DRAIN) ||
                (state == FILL);
    rd_en     = (state == CPY) && !abort_i;
    wr_en     = !abort_i &&
                (((state == CPY) && rd_pend) ||
                 (state == DRAIN) || (state == FILL));
    busy_o    = (state != IDLE);
    done_o    = (state == DONE);
    aborted_o = (state == DONE) && aborted_q;
    ram.wr_en   = wr_en;
    ram.wr_addr = wr_en ? dst_ptr : wr_addr_hold;
    ram.rd_addr = rd_en ? src_ptr : rd_hold;
    if (!wr_en)         ram.wr_data = wr_data_hold;
    else if (fill_mode) ram.wr_data = fill_q;
    else                ram.wr_data = ram.rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr      <= '0;
      dst_ptr      <= '0;
      rd_hold      <= '0;
      wr_addr_hold <= '0;
      wr_data_hold <= '0;
      fill_q       <= '0;
      cnt          <= '0;
      back         <= 1'b0;
      fill_mode    <= 1'b0;
      rd_pend      <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      // A read issued in CPY returns data for a write next cycle.
      rd_pend <= (state == CPY);
      if ((state == IDLE) && start_i) begin
        aborted_q <= 1'b0;
        cnt       <= len_i;
        fill_q    <= fill_data_i;
        fill_mode <= mode_i;
        back      <= back_nx;
        src_ptr   <= back_nx ? src_a + ofs : src_a;
        dst_ptr   <= back_nx ? dst_a + ofs : dst_a;
      end
      if (rd_en) begin
        rd_hold <= src_ptr;
        src_ptr <= src_ptr + step;
        cnt     <= cnt - LEN_W'(1);
      end
      if (wr_en) begin
        wr_addr_hold <= dst_ptr;
        wr_data_hold <= ram.wr_data;
        dst_ptr      <= dst_ptr + step;
        if (fill_mode) cnt <= cnt - LEN_W'(1);
      end
      if (active && abort_i) aborted_q <= 1'b1;
    end
  end

endmodule
